// File: rtl/ga_pkg.sv
// Shared GA types for the ALU datapath and its feeders.
//   ga_multivector_t : 8-component 3D multivector. Component 0 (scalar) sits
//                      in the LSBs, so it casts to/from [7:0][W-1:0] by index.
//   ga_funct_e       : ALU operation encoding. Codes 10..15 are undefined.
//   ga_col_state_e   : operand collector FSM states.
package ga_pkg;

  localparam int GA_DATA_W   = 32;
  localparam int GA_NUM_COMP = 8;

  localparam logic [2:0] GA_COMP_SCALAR = 3'd0;
  localparam logic [2:0] GA_COMP_X      = 3'd1;
  localparam logic [2:0] GA_COMP_Y      = 3'd2;
  localparam logic [2:0] GA_COMP_Z      = 3'd3;
  localparam logic [2:0] GA_COMP_XY     = 3'd4;
  localparam logic [2:0] GA_COMP_XZ     = 3'd5;
  localparam logic [2:0] GA_COMP_YZ     = 3'd6;
  localparam logic [2:0] GA_COMP_TRI    = 3'd7;

  // Declared MSB-first: trivector is the top slice, scalar the bottom.
  typedef struct packed {
    logic [GA_DATA_W-1:0] trivector;
    logic [GA_DATA_W-1:0] bivector_yz;
    logic [GA_DATA_W-1:0] bivector_xz;
    logic [GA_DATA_W-1:0] bivector_xy;
    logic [GA_DATA_W-1:0] vector_z;
    logic [GA_DATA_W-1:0] vector_y;
    logic [GA_DATA_W-1:0] vector_x;
    logic [GA_DATA_W-1:0] scalar;
  } ga_multivector_t;

  typedef enum logic [3:0] {
    GA_ADD     = 4'd0,
    GA_SUB     = 4'd1,
    GA_MUL     = 4'd2,
    GA_WEDGE   = 4'd3,
    GA_DOT     = 4'd4,
    GA_DUAL    = 4'd5,
    GA_REV     = 4'd6,
    GA_NORM    = 4'd7,
    GA_ROTATE  = 4'd8,
    GA_REFLECT = 4'd9
  } ga_funct_e;

  typedef enum logic [1:0] {
    COL_COLLECT = 2'd0,
    COL_ISSUE   = 2'd1,
    COL_HOLD    = 2'd2
  } ga_col_state_e;

  function automatic logic ga_funct_is_legal(input ga_funct_e f);
    logic ok;
    case (f)
      GA_ADD, GA_SUB, GA_MUL, GA_WEDGE, GA_DOT,
      GA_DUAL, GA_REV, GA_NORM, GA_ROTATE, GA_REFLECT: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ga_mv_regfile.sv
// Two multivector operand registers (A = sel 0, B = sel 1) with a single
// component write port, a synchronous clear, and a per-component written mask.
//   clk_i, rst_ni : clock, async active-low reset
//   i_clear       : zero both operands and the mask (wins over i_we)
//   i_we          : write i_data into component i_idx of operand i_sel
//   o_a, o_b      : registered operands
//   o_mask        : written bits, [7:0] = A, [15:8] = B
module ga_mv_regfile
  import ga_pkg::*;
#(
  parameter int DataWidth = GA_DATA_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_clear,
  input  logic                 i_we,
  input  logic                 i_sel,
  input  logic [2:0]           i_idx,
  input  logic [DataWidth-1:0] i_data,
  output ga_multivector_t      o_a,
  output ga_multivector_t      o_b,
  output logic [15:0]          o_mask
);

  logic [1:0][GA_NUM_COMP-1:0][DataWidth-1:0] r_mv;
  logic [1:0][GA_NUM_COMP-1:0]                r_mask;

  for (genvar g_op = 0; g_op < 2; g_op++) begin : g_opnd
    for (genvar g_c = 0; g_c < GA_NUM_COMP; g_c++) begin : g_comp
      logic w_hit;
      assign w_hit = i_we && (i_sel == 1'(g_op)) && (i_idx == 3'(g_c));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_mv[g_op][g_c]   <= '0;
          r_mask[g_op][g_c] <= 1'b0;
        end else if (i_clear) begin
          r_mv[g_op][g_c]   <= '0;
          r_mask[g_op][g_c] <= 1'b0;
        end else if (w_hit) begin
          r_mv[g_op][g_c]   <= i_data;
          r_mask[g_op][g_c] <= 1'b1;
        end
      end
    end
  end

  assign o_a    = ga_multivector_t'(r_mv[0]);
  assign o_b    = ga_multivector_t'(r_mv[1]);
  assign o_mask = r_mask;

endmodule

// File: rtl/ga_operand_collector.sv
// Upstream feeder for the GA ALU. Collects operands A and B one component at
// a time, then issues a single operation per command over valid/ready and
// freezes everything for HoldCycles cycles after the handshake, so a fresh
// valid never lands while the ALU sits in its done state (ready high, valid
// ignored). Operands persist across issues so they can be reused.
//   wr_*        : component write port (sel, idx, data), ready = wr_ready_o
//   clear_i     : zero operands and mask; only honoured in COLLECT
//   op_*        : issue request; undefined op_i pulses illegal_op_o
//   operand_*_o, operation_o, alu_valid_o, alu_ready_i : ALU side
//   written_o   : written mask, issue_count_o : completed handshakes (wraps)
// DataWidth must equal GA_DATA_W (the shared multivector type is fixed).
module ga_operand_collector
  import ga_pkg::*;
#(
  parameter int DataWidth  = GA_DATA_W,
  parameter int HoldCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic                 wr_sel_i,
  input  logic [2:0]           wr_idx_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 clear_i,
  input  logic                 op_valid_i,
  input  ga_funct_e            op_i,
  output logic                 op_ready_o,
  output ga_multivector_t      operand_a_o,
  output ga_multivector_t      operand_b_o,
  output ga_funct_e            operation_o,
  output logic                 alu_valid_o,
  input  logic                 alu_ready_i,
  output logic [15:0]          written_o,
  output logic                 illegal_op_o,
  output logic [15:0]          issue_count_o
);

  ga_col_state_e r_state, w_state_nxt;
  logic [2:0]    r_hold_cnt;
  ga_funct_e     r_op;
  logic          r_illegal;
  logic [15:0]   r_issue_cnt;

  logic w_wr_ready, w_op_ready, w_alu_valid;
  logic w_clear, w_we, w_op_acc, w_legal, w_hs;

  assign w_legal = ga_funct_is_legal(op_i);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_op_ready  = 1'b0;
    w_alu_valid = 1'b0;
    w_clear     = 1'b0;
    w_we        = 1'b0;
    w_op_acc    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      COL_COLLECT: begin
        w_wr_ready = !clear_i;
        w_op_ready = !clear_i;
        w_clear    = clear_i;
        w_we       = wr_valid_i && !clear_i;
        w_op_acc   = op_valid_i && !clear_i;
        if (w_op_acc && w_legal) w_state_nxt = COL_ISSUE;
      end
      COL_ISSUE: begin
        w_alu_valid = 1'b1;
        if (alu_ready_i) begin
          w_hs        = 1'b1;
          w_state_nxt = COL_HOLD;
        end
      end
      COL_HOLD: begin
        if (r_hold_cnt <= 3'd1) w_state_nxt = COL_COLLECT;
      end
      default: w_state_nxt = COL_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= COL_COLLECT;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_cnt  <= '0;
      r_op        <= GA_ADD;
      r_illegal   <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      r_illegal <= w_op_acc && !w_legal;
      if (w_op_acc && w_legal) r_op <= op_i;
      if (w_hs) begin
        r_hold_cnt  <= 3'(HoldCycles);
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end else if (r_state == COL_HOLD) begin
        r_hold_cnt <= r_hold_cnt - 3'd1;
      end
    end
  end

  // A write accepted in the same cycle as an op lands on the same edge the
  // FSM enters ISSUE, so it is part of the issued operands.
  ga_mv_regfile #(
    .DataWidth(DataWidth)
  ) u_regfile (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_clear(w_clear),
    .i_we   (w_we),
    .i_sel  (wr_sel_i),
    .i_idx  (wr_idx_i),
    .i_data (wr_data_i),
    .o_a    (operand_a_o),
    .o_b    (operand_b_o),
    .o_mask (written_o)
  );

  assign wr_ready_o    = w_wr_ready;
  assign op_ready_o    = w_op_ready;
  assign alu_valid_o   = w_alu_valid;
  assign operation_o   = r_op;
  assign illegal_op_o  = r_illegal;
  assign issue_count_o = r_issue_cnt;

endmodule

// File: doc/ga_operand_collector.md
Name: ga_operand_collector

Overview:
- Upstream feeder for the GA ALU.
- Assembles two full multivectors (operands A and B) from single-component DataWidth-bit writes issued by the core/bus side.
- Latches the requested ga_funct_e, issues one operation per command over the ALU valid/ready handshake, and holds operands stable for the ALU's compute window.
- Operand registers persist across issues, so an operand such as a rotor can be reused without re-writing it.

Parameters:
- DataWidth, 32, width of one multivector component.
- HoldCycles, 2, cycles operands are held stable after the ALU handshake (covers ALU compute + done cycles); legal range 1..7.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  component write request.
- wr_ready_o  out  1  write accepted when high with wr_valid_i.
- wr_sel_i  in  1  0 = operand A, 1 = operand B.
- wr_idx_i  in  3  component index: 0 scalar, 1 x, 2 y, 3 z, 4 xy, 5 xz, 6 yz, 7 trivector.
- wr_data_i  in  DataWidth  component value.
- clear_i  in  1  zero both operands and the written mask.
- op_valid_i  in  1  issue request.
- op_i  in  ga_funct_e  operation to issue.
- op_ready_o  out  1  issue request accepted when high with op_valid_i.
- operand_a_o  out  ga_multivector_t  to ALU operand A.
- operand_b_o  out  ga_multivector_t  to ALU operand B.
- operation_o  out  ga_funct_e  to ALU operation.
- alu_valid_o  out  1  to ALU valid.
- alu_ready_i  in  1  from ALU ready.
- written_o  out  16  per-component written mask; bits [7:0] = A, bits [15:8] = B.
- illegal_op_o  out  1  one-cycle pulse when an undefined op_i is accepted.
- issue_count_o  out  16  count of completed ALU handshakes.

Behaviour:
- Reset (async):
  - State COLLECT.
  - All operand registers, written_o, operation_o and issue_count_o are 0.
  - alu_valid_o = 0, illegal_op_o = 0.
  - wr_ready_o = op_ready_o = 1 once reset is released.
  - Reset mid-issue abandons the operation with no partial state retained.
- States: COLLECT, ISSUE, HOLD.
- COLLECT:
  - wr_ready_o = !clear_i; op_ready_o = !clear_i.
  - An accepted write updates the addressed component next edge and sets its written bit.
  - A write and an op accepted in the same cycle: the write is included in the issued operands.
  - clear_i has priority: operands and mask are zeroed, and any write or op that cycle is not accepted.
  - Accepted op with a legal op_i (ADD, SUB, MUL, WEDGE, DOT, DUAL, REV, NORM, ROTATE, REFLECT): latch operation_o and go to ISSUE.
  - Accepted op with any other encoding: pulse illegal_op_o next cycle, stay in COLLECT, no ALU traffic.
  - Unwritten components issue as their current register value (zero after reset/clear). Incomplete masks are not an error.
- ISSUE:
  - alu_valid_o = 1; wr_ready_o = op_ready_o = 0.
  - Handshake = alu_valid_o & alu_ready_i.
  - On handshake: alu_valid_o drops next cycle, issue_count_o increments (wraps 0xFFFF to 0), hold counter loads HoldCycles, go to HOLD.
  - clear_i is ignored outside COLLECT.
- HOLD:
  - alu_valid_o = 0; operands and operation_o frozen; wr/op ready = 0.
  - Counter decrements each cycle; at 1, go to COLLECT.
  - This prevents a new valid reaching the ALU while it sits in its done state, where ready is high but valid is ignored.
- Latency with alu_ready_i high:
  - op accepted cycle t.
  - alu_valid_o high in t+1; handshake in t+1.
  - HOLD in t+2 and t+3.
  - op_ready_o high again in t+4.
- operand_*_o and operation_o are driven straight from registers; there is no combinational path from wr_* or op_* to the ALU side.

Decomposition:
- ga_pkg:
  - ga_multivector_t and ga_funct_e (already shared).
  - Add a GA_COMP_* localparam index set (0..7).
  - Add the function ga_funct_is_legal(ga_funct_e).
  - Add the collector state enum.
- One natural sub-module, ga_mv_regfile: two multivectors with per-component write enables, clear, and mask. The FSM and counters stay in the top.

Test Plan:
- Write A = {scalar 1, x 2}, B = {y 3}, issue ADD, alu_ready_i = 1 -> alu_valid_o high exactly 1 cycle; operand_a_o.scalar = 1, vector_x = 2; operand_b_o.vector_y = 3; written_o = 16'h0403; issue_count_o = 1; op_ready_o back after 4 cycles.
- Issue MUL with alu_ready_i held 0 for 5 cycles -> alu_valid_o stays high 5 cycles, operands stable, wr_ready_o = 0 throughout; handshake on cycle 6.
- Write B.trivector = 7 in the same cycle as op MUL -> issued operand_b_o.trivector = 7.
- op_i = undefined encoding -> illegal_op_o pulses 1 cycle, alu_valid_o never rises, issue_count_o unchanged.
- clear_i together with wr_valid_i and op_valid_i -> neither accepted; all operands 0; written_o = 0.
- Assert rst_ni low during HOLD, and separately issue 65536 ops -> everything returns to reset values; issue_count_o wraps to 0.
